count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receive-side monitor for the free-running 4-bit counter output bus. It samples the counter value each valid cycle, acquires lock after a run of correct +1 increments, then flags and counts every sequence break. It sits downstream of the counter, on the same clock, and feeds status and diagnostics logic.

## Interface
- WIDTH, 4: width of the monitored count bus.
- LOCK_LEN, 3: consecutive correct increments required to declare lock (1..15).
- ERR_W, 8: width of the saturating error counter.

- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- din  input  WIDTH  sampled count value.
- din_valid  input  1  din is meaningful this cycle.
- clr_err  input  1  clears err_count (one-cycle request).
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse per detected sequence break.
- err_count  output  ERR_W  saturating count of sequence breaks.
- expected  output  WIDTH  next value the checker expects (ref+1 mod 2^WIDTH).

## Operation
- Internal state:
  - state ∈ {HUNT, LOCKED}.
  - ref: last accepted value, WIDTH bits.
  - have_ref: 1 bit.
  - run: 0..LOCK_LEN.
- Match rule: din == (ref + 1) mod 2^WIDTH; the wrap from 2^WIDTH−1 to 0 is a match.
- Cycles with din_valid=0 change nothing except clr_err handling; err_pulse is 0 on those cycles.
- HUNT, valid sample:
  - have_ref=0: ref←din, have_ref←1, run←0.
  - Match: run←run+1, ref←din. If run+1 == LOCK_LEN, then state←LOCKED and run←0.
  - Mismatch: run←0, ref←din. No error is reported.
- LOCKED, valid sample:
  - Match: ref←din.
  - Mismatch: err_pulse←1, err_count sat-increments, state←HUNT, ref←din, run←0, have_ref stays 1.
- A mismatch is counted only in LOCKED. Repeated values and backward steps count as mismatches.
- err_count saturates at 2^ERR_W−1 and never wraps.
- clr_err:
  - Alone: err_count←0.
  - Same cycle as a counted error: err_count←1.
- expected = ref+1 mod 2^WIDTH. It is 0 while have_ref=0.

## Timing
- All outputs are registered and reflect the sample taken on the previous rising edge (1-cycle latency).
- locked rises on the edge that samples the LOCK_LEN-th consecutive match.
  - With LOCK_LEN=3 this is the 4th consecutive valid sample after reset.
- err_pulse is high for exactly one cycle per break. Back-to-back breaks give back-to-back pulses only if each occurs in LOCKED. The second break after a drop lands in HUNT and is not counted.
- Reset values: locked=0, err_pulse=0, err_count=0, expected=0, state=HUNT, have_ref=0, ref=0, run=0.
- rst has priority over all inputs. Asserting rst mid-run or mid-lock discards lock and err_count on that edge.

## Configuration
- COUNT_CHECK_WRAP_FLAG_EN:
  - Defined: adds output wrap_seen (1 bit, registered, reset 0). It pulses for one cycle when a matching sample in LOCKED steps from 2^WIDTH−1 to 0.
  - Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then din=0,1,2,3 valid on consecutive cycles -> locked=1 in the cycle after din=3 is sampled, err_count=0, expected=4.
- Locked at din=5, then din=7 -> err_pulse=1 for one cycle, err_count=1, locked=0. Next samples 8,9,10 -> relock after 10, err_count stays 1.
- Locked, din=14,15,0,1 -> no error, locked stays 1. With COUNT_CHECK_WRAP_FLAG_EN, wrap_seen pulses once, the cycle after 0 is sampled.
- Locked, din_valid=0 for 10 cycles, then din continues at ref+1 -> no error, locked held.
- ERR_W=2: force 5 separate lock-then-break episodes -> err_count saturates at 3. clr_err concurrent with the 6th break -> err_count=1.
- Locked with err_count=2, assert rst one cycle -> next cycle locked=0, err_count=0, expected=0, err_pulse=0.

Source files
------------

// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running WIDTH-bit counter bus: locks after LOCK_LEN +1 steps, then flags and counts breaks.
// Optional feature: define COUNT_CHECK_WRAP_FLAG_EN to add the wrap_seen output.
module count_seq_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_LEN = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
`ifdef COUNT_CHECK_WRAP_FLAG_EN
   ,
   output logic             wrap_seen
`endif
);

   localparam int RUN_W = $clog2(LOCK_LEN + 1);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t           state_p0, state_nxt;
   logic [WIDTH-1:0] ref_p0, ref_nxt;
   logic             have_ref_p0, have_ref_nxt;
   logic [RUN_W-1:0] run_p0, run_nxt;
   logic [RUN_W-1:0] run_inc;

   logic             locked_p0, locked_nxt;
   logic             err_pulse_p0, err_pulse_nxt;
   logic [ERR_W-1:0] err_count_p0, err_count_nxt;
   logic [WIDTH-1:0] expected_p0, expected_nxt;
   logic             wrap_p0, wrap_nxt;

   logic [WIDTH-1:0] ref_inc;
   logic             match;
   logic             brk;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   assign ref_inc = ref_p0 + WIDTH'(1);
   assign run_inc = run_p0 + RUN_W'(1);
   assign match   = have_ref_p0 && (din == ref_inc);
   assign brk     = din_valid && (state_p0 == LOCK) && !match;

   // Register stage: checker state and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0     <= HUNT;
         ref_p0       <= '0;
         have_ref_p0  <= 1'b0;
         run_p0       <= '0;
         locked_p0    <= 1'b0;
         err_pulse_p0 <= 1'b0;
         err_count_p0 <= '0;
         expected_p0  <= '0;
         wrap_p0      <= 1'b0;
      end else begin
         state_p0     <= state_nxt;
         ref_p0       <= ref_nxt;
         have_ref_p0  <= have_ref_nxt;
         run_p0       <= run_nxt;
         locked_p0    <= locked_nxt;
         err_pulse_p0 <= err_pulse_nxt;
         err_count_p0 <= err_count_nxt;
         expected_p0  <= expected_nxt;
         wrap_p0      <= wrap_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_p0;
      ref_nxt      = ref_p0;
      have_ref_nxt = have_ref_p0;
      run_nxt      = run_p0;
      if (din_valid) begin
         ref_nxt      = din;
         have_ref_nxt = 1'b1;
         case (state_p0)
            HUNT: begin
               if (!have_ref_p0) begin
                  run_nxt = '0;
               end else if (match) begin
                  if (run_inc == RUN_W'(LOCK_LEN)) begin
                     state_nxt = LOCK;
                     run_nxt   = '0;
                  end else begin
                     run_nxt = run_inc;
                  end
               end else begin
                  run_nxt = '0;
               end
            end
            LOCK: begin
               if (!match) begin
                  state_nxt = HUNT;
                  run_nxt   = '0;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      err_pulse_nxt = brk;
      err_count_nxt = err_count_p0;
      if (brk)
         err_count_nxt = clr_err ? ERR_W'(1) : sat_inc(err_count_p0);
      else if (clr_err)
         err_count_nxt = '0;
      locked_nxt   = (state_nxt == LOCK);
      expected_nxt = have_ref_nxt ? ref_nxt + WIDTH'(1) : '0;
      wrap_nxt     = din_valid && (state_p0 == LOCK) && match && (&ref_p0);
   end

   assign locked    = locked_p0;
   assign err_pulse = err_pulse_p0;
   assign err_count = err_count_p0;
   assign expected  = expected_p0;

`ifdef COUNT_CHECK_WRAP_FLAG_EN
   assign wrap_seen = wrap_p0;
`else
   logic unused_wrap;
   assign unused_wrap = wrap_p0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker (ERR_W=2): a behavioural model pushes expected outputs per driven cycle.
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din;
   logic       din_valid;
   logic       clr_err;
   logic       locked;
   logic       err_pulse;
   logic [1:0] err_count;
   logic [3:0] expected;
`ifdef COUNT_CHECK_WRAP_FLAG_EN
   logic       wrap_seen;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count_seq_checker #(.WIDTH(4), .LOCK_LEN(3), .ERR_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .clr_err   (clr_err),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .expected  (expected)
`ifdef COUNT_CHECK_WRAP_FLAG_EN
      ,
      .wrap_seen (wrap_seen)
`endif
   );

   typedef struct packed {
      logic       lk;
      logic       pulse;
      logic [1:0] cnt;
      logic [3:0] exp;
      logic       wrap;
   } exp_t;

   exp_t q[$];

   // reference model state
   logic       m_locked = 1'b0;
   logic [3:0] m_ref    = 4'd0;
   logic       m_have   = 1'b0;
   int         m_run    = 0;
   logic [1:0] m_err    = 2'd0;
   int         n_pulses = 0;
   int         n_wraps  = 0;

   task automatic model(input logic r, input logic v, input logic [3:0] d, input logic c);
      exp_t       e;
      logic       pulse = 1'b0;
      logic       wrap  = 1'b0;
      logic [3:0] nxt   = m_ref + 4'd1;
      if (r) begin
         m_locked = 0; m_ref = 0; m_have = 0; m_run = 0; m_err = 0;
      end else begin
         if (v) begin
            if (!m_locked) begin
               if (!m_have) begin
                  m_have = 1; m_run = 0;
               end else if (d == nxt) begin
                  m_run++;
                  if (m_run == 3) begin m_locked = 1; m_run = 0; end
               end else begin
                  m_run = 0;
               end
            end else begin
               if (d == nxt) begin
                  if (m_ref == 4'hF) wrap = 1;
               end else begin
                  pulse = 1; m_locked = 0; m_run = 0;
               end
            end
            m_ref = d;
         end
         if (pulse) m_err = c ? 2'd1 : ((m_err == 2'd3) ? 2'd3 : m_err + 2'd1);
         else if (c) m_err = 2'd0;
      end
      e.lk    = m_locked;
      e.pulse = pulse;
      e.cnt   = m_err;
      e.exp   = m_have ? m_ref + 4'd1 : 4'd0;
      e.wrap  = wrap;
      q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty: observed 0 entries, expected 1", tag);
         return;
      end
      e = q.pop_front();
      checks++;
      assert (locked === e.lk) else begin
         errors++;
         $error("FAIL %s locked: observed %b expected %b", tag, locked, e.lk);
      end
      checks++;
      assert (err_pulse === e.pulse) else begin
         errors++;
         $error("FAIL %s err_pulse: observed %b expected %b", tag, err_pulse, e.pulse);
      end
      checks++;
      assert (err_count === e.cnt) else begin
         errors++;
         $error("FAIL %s err_count: observed %0d expected %0d", tag, err_count, e.cnt);
      end
      checks++;
      assert (expected === e.exp) else begin
         errors++;
         $error("FAIL %s expected: observed %0d expected %0d", tag, expected, e.exp);
      end
`ifdef COUNT_CHECK_WRAP_FLAG_EN
      checks++;
      assert (wrap_seen === e.wrap) else begin
         errors++;
         $error("FAIL %s wrap_seen: observed %b expected %b", tag, wrap_seen, e.wrap);
      end
`endif
      if (e.pulse) n_pulses++;
      if (e.wrap)  n_wraps++;
   endtask

   task automatic step(input string tag, input logic r, input logic v, input logic [3:0] d,
                       input logic c);
      rst = r; din_valid = v; din = d; clr_err = c;
      model(r, v, d, c);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic feed(input string tag, input logic [3:0] d);
      step(tag, 1'b0, 1'b1, d, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected summary before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; clr_err = 1'b0;
      @(posedge clk); #1;
      step("reset", 1'b1, 1'b0, 4'd0, 1'b0);
      step("reset2", 1'b1, 1'b1, 4'd9, 1'b1);

      // acquire lock on 0,1,2,3
      for (int i = 0; i < 4; i++) feed("acquire", 4'(i));
      checks++;
      assert (locked === 1'b1 && expected === 4'd4 && err_count === 2'd0) else begin
         errors++;
         $error("FAIL lock_after_3: observed lk=%b exp=%0d cnt=%0d expected lk=1 exp=4 cnt=0",
                locked, expected, err_count);
      end

      // break at 5 -> 7, relock on 8,9,10
      feed("run", 4'd4);
      feed("run", 4'd5);
      feed("break_skip", 4'd7);
      feed("relock", 4'd8);
      feed("relock", 4'd9);
      feed("relock", 4'd10);

      // wrap through 15 -> 0
      for (int i = 11; i < 16; i++) feed("pre_wrap", 4'(i));
      feed("wrap", 4'd0);
      feed("post_wrap", 4'd1);

      // idle gap with garbage on din
      for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
      feed("resume", 4'd2);
      feed("resume", 4'd3);

      // repeated breaks to saturate the 2-bit counter
      feed("brk2", 4'd9);
      for (int i = 10; i < 13; i++) feed("relock", 4'(i));
      feed("brk3", 4'd0);
      for (int i = 1; i < 4; i++) feed("relock", 4'(i));
      feed("brk_repeat", 4'd3);
      for (int i = 4; i < 7; i++) feed("relock", 4'(i));
      feed("brk_back", 4'd5);
      for (int i = 6; i < 9; i++) feed("relock", 4'(i));
      checks++;
      assert (err_count === 2'd3) else begin
         errors++;
         $error("FAIL saturate: observed %0d expected 3", err_count);
      end
      feed("brk_drop", 4'd1);
      feed("brk_in_hunt", 4'd1);
      for (int i = 2; i < 5; i++) feed("relock", 4'(i));
      step("brk_with_clr", 1'b0, 1'b1, 4'd9, 1'b1);
      checks++;
      assert (err_count === 2'd1) else begin
         errors++;
         $error("FAIL clr_with_break: observed %0d expected 1", err_count);
      end
      step("clr_alone", 1'b0, 1'b0, 4'd0, 1'b1);

      // lock, two errors, then reset mid-lock
      for (int i = 10; i < 14; i++) feed("lock", 4'(i));
      feed("e1", 4'd0);
      for (int i = 1; i < 4; i++) feed("lock", 4'(i));
      feed("e2", 4'd8);
      for (int i = 9; i < 12; i++) feed("lock", 4'(i));
      step("mid_reset", 1'b1, 1'b1, 4'd12, 1'b0);
      checks++;
      assert (locked === 1'b0 && err_count === 2'd0 && expected === 4'd0 && err_pulse === 1'b0)
      else begin
         errors++;
         $error("FAIL reset_mid_lock: observed lk=%b cnt=%0d exp=%0d pulse=%b expected all 0",
                locked, err_count, expected, err_pulse);
      end

      // randomised mostly-incrementing traffic
      for (int i = 0; i < 400; i++) begin
         logic [3:0] d;
         d = ($urandom_range(0, 9) < 8) ? m_ref + 4'd1 : 4'($urandom_range(0, 15));
         step("random", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), d,
              ($urandom_range(0, 15) == 0));
      end

      checks++;
      assert (n_pulses > 5) else begin
         errors++;
         $error("FAIL coverage_pulses: observed %0d expected >5", n_pulses);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
